// File: rtl/display_scan_timer.sv
// Time-multiplexed LED digit scanner: one-hot channel enable with run-time dwell and optional blanking gap.
// Latency: all outputs registered; ch_en follows an enable edge by one cycle (start and stop).
// Backpressure: none; enable low parks the scan in IDLE with all channels off.
module display_scan_timer #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 25,
  parameter int BLANK_CYC = 0,
  parameter int IDX_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  period,
  output logic [IDX_W-1:0]  ch_idx,
  output logic [NUM_CH-1:0] ch_en,
  output logic              blank,
  output logic              frame_tick
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  // Terminal count of the blanking gap; unused when blanking is disabled.
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_CH - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic                blank_q, blank_d;
  logic                ft_q, ft_d;

  logic                adv;
  logic                idx_wrap;
  logic [IDX_W-1:0]    idx_nxt;

  function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == IDX_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Channel successor with wrap; a single-channel bank wraps on every advance.
  always_comb begin
    idx_wrap = (idx_q == LAST_IDX);
    idx_nxt  = idx_wrap ? '0 : idx_q + 1'b1;
  end

  // Next-state and next-output logic; enable low takes priority over any terminal count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    idx_d    = idx_q;
    ch_en_d  = ch_en_q;
    blank_d  = blank_q;
    ft_d     = 1'b0;
    adv      = 1'b0;

    case (state_q)
      S_IDLE: begin
        ch_en_d = '0;
        blank_d = 1'b0;
        if (enable) begin
          state_d  = S_ON;
          cnt_d    = '0;
          idx_d    = '0;
          period_d = period;
          ch_en_d  = onehot('0);
        end
      end
      S_ON: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ch_en_d = '0;
          blank_d = 1'b0;
        end else if (cnt_q == period_q) begin
          cnt_d = '0;
          if (BLANK_CYC == 0) begin
            adv = 1'b1;
          end else begin
            state_d = S_BLANK;
            ch_en_d = '0;
            blank_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BLANK: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ch_en_d = '0;
          blank_d = 1'b0;
        end else if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = S_ON;
          blank_d = 1'b0;
          adv     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        ch_en_d = '0;
        blank_d = 1'b0;
      end
    endcase

    // Moving to the next digit re-samples the dwell and flags the frame wrap.
    if (adv) begin
      idx_d    = idx_nxt;
      period_d = period;
      ch_en_d  = onehot(idx_nxt);
      ft_d     = idx_wrap;
    end
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      idx_q    <= '0;
      ch_en_q  <= '0;
      blank_q  <= 1'b0;
      ft_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      idx_q    <= idx_d;
      ch_en_q  <= ch_en_d;
      blank_q  <= blank_d;
      ft_q     <= ft_d;
    end
  end

  assign ch_idx     = idx_q;
  assign ch_en      = ch_en_q;
  assign blank      = blank_q;
  assign frame_tick = ft_q;

endmodule
